// File: rtl/spi_pkg.sv
// Shared constants and phase encoding for the SPI byte-to-word packer.
package spi_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W_DEFAULT = 16;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } phase_e;

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous word FIFO: power-of-two depth, simultaneous push/pop allowed even when full.
module sync_word_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    output logic [WORD_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign level    = count;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_word_packer.sv
// Packs pairs of SPI bytes into CPU words through a FIFO and serves a CPU response word back byte by byte.
module spi_word_packer
    import spi_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_cs,
    input  logic                     rx_byte_ready,
    input  logic [BYTE_W-1:0]        rx_byte,
    output logic [BYTE_W-1:0]        tx_byte,
    // word_valid/word_ready: a word transfers on a rising edge where both are high; word_out is 0 while not valid.
    output logic [WORD_W-1:0]        word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    input  logic [WORD_W-1:0]        tx_word,
    input  logic                     tx_load,
    input  logic                     clr_flags,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     short_frame,
    output phase_e                   phase_state
);

    phase_e            phase;
    logic [BYTE_W-1:0] hi_byte;
    logic [WORD_W-1:0] active_tx;
    logic [WORD_W-1:0] pending_tx;
    logic              pending_valid;
    logic              rx_fire;
    logic              push;
    logic              abort;
    logic              to_hi;
    logic              full;
    logic              empty;
    logic              overflow_evt;

    assign rx_fire      = rx_byte_ready && !spi_cs;
    assign push         = rx_fire && (phase == WAIT_LO);
    assign abort        = spi_cs && (phase == WAIT_LO);
    assign to_hi        = push || abort;
    assign overflow_evt = push && full && !word_ready;
    assign word_valid   = !empty;
    assign phase_state  = phase;
    assign tx_byte      = (phase == WAIT_HI) ? active_tx[WORD_W-1 -: BYTE_W] : active_tx[BYTE_W-1:0];

    sync_word_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (WORD_W'({hi_byte, rx_byte})),
        .pop       (word_ready),
        .pop_data  (word_out),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= WAIT_HI;
            hi_byte <= '0;
        end else if (abort) begin
            phase <= WAIT_HI;
        end else if (rx_fire) begin
            if (phase == WAIT_HI) begin
                hi_byte <= rx_byte;
                phase   <= WAIT_LO;
            end else begin
                phase <= WAIT_HI;
            end
        end
    end

    // A reload mid-frame is parked so the low byte of the current word is not disturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_tx     <= '0;
            pending_tx    <= '0;
            pending_valid <= 1'b0;
        end else if (phase == WAIT_HI) begin
            if (tx_load) active_tx <= tx_word;
        end else if (to_hi) begin
            if (tx_load)            active_tx <= tx_word;
            else if (pending_valid) active_tx <= pending_tx;
            pending_valid <= 1'b0;
        end else if (tx_load) begin
            pending_tx    <= tx_word;
            pending_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            overflow    <= overflow_evt || (overflow && !clr_flags);
            short_frame <= abort || (short_frame && !clr_flags);
        end
    end

endmodule

// File: tb/tb_spi_word_packer.sv
// Directed bench for spi_word_packer with a queue-based scoreboard on the word output.
module tb_spi_word_packer;
    import spi_pkg::*;

    localparam int DEPTH  = 4;
    localparam int WORD_W = 16;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_cs;
    logic              rx_byte_ready;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_byte;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] tx_word;
    logic              tx_load;
    logic              clr_flags;
    logic [LW-1:0]     fifo_level;
    logic              overflow;
    logic              short_frame;
    phase_e            phase_state;

    int checks   = 0;
    int failures = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] mon_exp;

    spi_word_packer #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_cs        (spi_cs),
        .rx_byte_ready (rx_byte_ready),
        .rx_byte       (rx_byte),
        .tx_byte       (tx_byte),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .tx_word       (tx_word),
        .tx_load       (tx_load),
        .clr_flags     (clr_flags),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .short_frame   (short_frame),
        .phase_state   (phase_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares each transferred word against the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", word_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("word_order", word_out, mon_exp);
                end
            end else if (!word_valid) begin
                check("word_out_zero_when_empty", word_out, 0);
            end
        end
    end

    // Driver tasks: all are entered 1 time unit after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte       = b;
        rx_byte_ready = 1'b1;
        idle(1);
        rx_byte_ready = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic drain();
        word_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            idle(1);
            if (fifo_level == 0) break;
        end
        word_ready = 1'b0;
        check("drain_level", fifo_level, 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst           = 1'b1;
        spi_cs        = 1'b0;
        rx_byte_ready = 1'b0;
        rx_byte       = '0;
        word_ready    = 1'b0;
        tx_word       = '0;
        tx_load       = 1'b0;
        clr_flags     = 1'b0;

        // Reset state
        #12;
        check("rst_level", fifo_level, 0);
        check("rst_valid", word_valid, 0);
        check("rst_word_out", word_out, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_overflow", overflow, 0);
        check("rst_short", short_frame, 0);
        check("rst_phase", phase_state, WAIT_HI);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Single word, latency 1
        send_byte(8'hA5);
        check("lat_valid_before", word_valid, 0);
        check("phase_lo", phase_state, WAIT_LO);
        send_byte(8'h3C);
        check("lat_valid_after", word_valid, 1);
        check("word_a53c", word_out, 16'hA53C);
        check("level_one", fifo_level, 1);
        exp_q.push_back(16'hA53C);
        drain();
        word_ready = 1'b1;
        idle(3);
        check("pop_empty_level", fifo_level, 0);
        word_ready = 1'b0;

        // Overflow: five words into depth four
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h4444);
        send_word(16'h5555);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", word_out, 16'h1111);
        drain();
        check("ovf_sticky", overflow, 1);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop in the same cycle
        send_word(16'h0A01);
        send_word(16'h0A02);
        send_word(16'h0A03);
        send_word(16'h0A04);
        exp_q.push_back(16'h0A01);
        exp_q.push_back(16'h0A02);
        exp_q.push_back(16'h0A03);
        exp_q.push_back(16'h0A04);
        check("full_level", fifo_level, 4);
        rx_byte       = 8'h0A;
        rx_byte_ready = 1'b1;
        idle(1);
        rx_byte    = 8'h05;
        word_ready = 1'b1;
        idle(1);
        rx_byte_ready = 1'b0;
        word_ready    = 1'b0;
        exp_q.push_back(16'h0A05);
        check("pushpop_level", fifo_level, 4);
        check("pushpop_overflow", overflow, 0);
        check("pushpop_head", word_out, 16'h0A02);
        drain();

        // Short frame and bytes ignored while deselected
        send_byte(8'h12);
        check("short_phase_lo", phase_state, WAIT_LO);
        spi_cs = 1'b1;
        idle(1);
        check("short_flag", short_frame, 1);
        check("short_phase_hi", phase_state, WAIT_HI);
        rx_byte       = 8'h99;
        rx_byte_ready = 1'b1;
        idle(1);
        rx_byte_ready = 1'b0;
        check("cs_ignore_phase", phase_state, WAIT_HI);
        check("cs_ignore_level", fifo_level, 0);
        spi_cs = 1'b0;
        send_byte(8'h34);
        send_byte(8'h56);
        exp_q.push_back(16'h3456);
        check("short_word", word_out, 16'h3456);
        check("short_level", fifo_level, 1);
        drain();
        send_byte(8'h77);
        spi_cs    = 1'b1;
        clr_flags = 1'b1;
        idle(1);
        spi_cs    = 1'b0;
        clr_flags = 1'b0;
        check("set_wins_clear", short_frame, 1);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        check("short_cleared", short_frame, 0);

        // Response word: immediate load, deferred load, overwrite, persistence
        check("tx_initial", tx_byte, 8'h00);
        tx_word = 16'hBEEF;
        tx_load = 1'b1;
        idle(1);
        tx_load = 1'b0;
        check("tx_hi_be", tx_byte, 8'hBE);
        send_byte(8'h00);
        check("tx_lo_ef", tx_byte, 8'hEF);
        tx_word = 16'h9999;
        tx_load = 1'b1;
        idle(1);
        tx_word = 16'h1234;
        idle(1);
        tx_load = 1'b0;
        check("tx_pending_hold", tx_byte, 8'hEF);
        send_byte(8'h01);
        exp_q.push_back(16'h0001);
        check("tx_boundary_12", tx_byte, 8'h12);
        send_byte(8'hAB);
        check("tx_lo_34", tx_byte, 8'h34);
        send_byte(8'hCD);
        exp_q.push_back(16'hABCD);
        check("tx_persist_12", tx_byte, 8'h12);
        drain();

        // Asynchronous reset mid-frame with words queued
        send_word(16'h1111);
        send_word(16'h2222);
        send_byte(8'hEE);
        check("pre_rst_level", fifo_level, 2);
        check("pre_rst_tx", tx_byte, 8'h34);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", word_valid, 0);
        check("arst_level", fifo_level, 0);
        check("arst_word_out", word_out, 0);
        check("arst_tx_byte", tx_byte, 0);
        check("arst_phase", phase_state, WAIT_HI);
        check("arst_overflow", overflow, 0);
        check("arst_short", short_frame, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h56);
        send_byte(8'h78);
        exp_q.push_back(16'h5678);
        check("post_rst_word", word_out, 16'h5678);
        drain();

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
